// File: rtl/ramdac_pkg.sv
// Shared encodings for the framebuffer write arbiter: FSM states and grant identities.
package ramdac_pkg;

    // Arbiter sweep state: idle, or a clear sweep in progress.
    typedef enum logic {
        ARBITER_IDLE  = 1'b0,
        ARBITER_CLEAR = 1'b1
    } arbiter_state_t;

    // Which requester owns the RAM write port in the current cycle.
    typedef enum logic {
        GRANT_HOST  = 1'b0,
        GRANT_CLEAR = 1'b1
    } grant_t;

endpackage

// File: rtl/framebuffer_write_arbiter_round_robin.sv
// Two-requester round-robin grant for the framebuffer write port.
// The last-grant register only moves on contended cycles, so an uncontended
// stream from one side never costs the other side its turn.
module round_robin_arbiter_2
    import ramdac_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   host_request,
    input  logic   clear_request,
    output logic   grant_valid,
    output grant_t grant
);

    grant_t last_grant;

    // Pick the sole requester, or the one that did not win the previous contention.
    always_comb begin
        grant_valid = host_request | clear_request;
        if (host_request && clear_request) begin
            grant = (last_grant == GRANT_CLEAR) ? GRANT_HOST : GRANT_CLEAR;
        end else if (host_request) begin
            grant = GRANT_HOST;
        end else begin
            grant = GRANT_CLEAR;
        end
    end

    // Remember the winner of each contended cycle; reset favours the host next time.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_CLEAR;
        end else if (host_request && clear_request) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Framebuffer RAM write-port owner: shares the port between the host pixel
// stream and an internal clear engine that fills a linear address range.
// Build option: define ROUND_ROBIN_EN for alternating grants on contention;
// otherwise the host has fixed priority and a held host stalls the sweep.
module framebuffer_write_arbiter
    import ramdac_pkg::*;
#(
    parameter int DATA_WIDTH         = 12,
    parameter int ADDRESS_SIZE       = 13,
    parameter int CLEAR_LAST_ADDRESS = 2**ADDRESS_SIZE-1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic [ADDRESS_SIZE-1:0] host_address,
    input  logic [DATA_WIDTH-1:0]   host_data,
    input  logic                    clear_start,
    input  logic [DATA_WIDTH-1:0]   clear_color,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic                    ram_write_enable,
    output logic [ADDRESS_SIZE-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0]   ram_write_data
);

    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS = ADDRESS_SIZE'(CLEAR_LAST_ADDRESS);

    arbiter_state_t          state;
    logic [ADDRESS_SIZE-1:0] clear_counter;
    logic [DATA_WIDTH-1:0]   clear_latched_color;
    logic                    clear_request;
    logic                    grant_valid;
    grant_t                  grant_who;
    logic                    clear_grant;

    assign clear_request = (state == ARBITER_CLEAR);

`ifdef ROUND_ROBIN_EN
    round_robin_arbiter_2 u_arbiter (
        .clock         (clock),
        .reset         (reset),
        .host_request  (host_valid),
        .clear_request (clear_request),
        .grant_valid   (grant_valid),
        .grant         (grant_who)
    );
`else
    // Fixed priority: the host always wins, the sweep only advances in host gaps.
    always_comb begin
        grant_valid = host_valid | clear_request;
        grant_who   = host_valid ? GRANT_HOST : GRANT_CLEAR;
    end
`endif

    assign clear_grant = grant_valid && (grant_who == GRANT_CLEAR);
    assign host_ready  = grant_valid && (grant_who == GRANT_HOST);
    assign clear_busy  = clear_request;

    // Sweep FSM, counter, colour latch and the registered RAM write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= ARBITER_IDLE;
            clear_counter       <= '0;
            clear_latched_color <= '0;
            clear_done          <= 1'b0;
            ram_write_enable    <= 1'b0;
            ram_write_address   <= '0;
            ram_write_data      <= '0;
        end else begin
            ram_write_enable <= grant_valid;
            clear_done       <= 1'b0;
            if (grant_valid) begin
                if (grant_who == GRANT_HOST) begin
                    ram_write_address <= host_address;
                    ram_write_data    <= host_data;
                end else begin
                    ram_write_address <= clear_counter;
                    ram_write_data    <= clear_latched_color;
                end
            end
            case (state)
                ARBITER_IDLE: begin
                    if (clear_start) begin
                        state               <= ARBITER_CLEAR;
                        clear_counter       <= '0;
                        clear_latched_color <= clear_color;
                    end
                end
                ARBITER_CLEAR: begin
                    if (clear_grant) begin
                        if (clear_counter == LAST_ADDRESS) begin
                            state      <= ARBITER_IDLE;
                            clear_done <= 1'b1;
                        end else begin
                            clear_counter <= clear_counter + 1'b1;
                        end
                    end
                end
                default: state <= ARBITER_IDLE;
            endcase
        end
    end

endmodule
